// File: rtl/instruction_fetch_unit.sv
//============================================================================
// Module      : instruction_fetch_unit
// Description : Reads num_inst consecutive words from the instruction memory
//               read port (port B), starting at base_addr, buffers them in a
//               small show-ahead FIFO and hands them to the decoder over a
//               valid/ready stream. The final word carries inst_last; done
//               pulses once when the fetch completes.
// Ports       : clk, reset (sync, active-high)
//               start, base_addr, num_inst, flush   - control
//               busy, done                           - status
//               imem_read_req/addr, imem_read_data   - imem port B (1-cycle)
//               inst_valid/data/last, inst_ready     - decoder stream
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module instruction_fetch_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int FIFO_DEPTH = 4,
  parameter int COUNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [COUNT_W-1:0]    num_inst,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic                  imem_read_req,
  output logic [ADDR_WIDTH-1:0] imem_read_addr,
  input  logic [DATA_WIDTH-1:0] imem_read_data,
  output logic                  inst_valid,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic                  inst_last,
  input  logic                  inst_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W+1:0] C_DEPTH = (PTR_W+2)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [COUNT_W-1:0]    r_num;
  logic [COUNT_W-1:0]    r_issued;
  logic [COUNT_W-1:0]    r_delivered;
  logic                  r_inflight;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W:0]        r_count;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

  logic                  w_active;
  logic                  w_flush;
  logic                  w_go;
  logic [PTR_W+1:0]      w_occ;
  logic                  w_req;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_valid;
  logic                  w_last;
  logic [COUNT_W-1:0]    w_num_m1;
  logic [ADDR_WIDTH+COUNT_W-1:0] w_addr_sum;

  assign w_active = (r_state != S_IDLE);
  // flush only acts on an active fetch; in IDLE it merely blocks start
  assign w_flush  = flush && w_active;
  assign w_go     = (r_state == S_IDLE) && start && !flush;
  assign w_num_m1 = r_num - COUNT_W'(1);

  // Credit check uses the pre-pop occupancy plus the read still in flight,
  // so the word returning next cycle always has a free slot.
  assign w_occ = {1'b0, r_count} + {{(PTR_W+1){1'b0}}, r_inflight};
  assign w_req = (r_state == S_FETCH) && !flush && (w_occ < C_DEPTH) &&
                 (r_issued < r_num);

  // Read data returning for a flushed request is dropped here.
  assign w_push  = r_inflight && !w_flush;
  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid && inst_ready;
  assign w_last  = w_valid && (r_delivered == w_num_m1);

  assign w_addr_sum = {{COUNT_W{1'b0}}, r_base} + {{ADDR_WIDTH{1'b0}}, r_issued};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_go) w_next = (num_inst == '0) ? S_DONE : S_FETCH;
      S_FETCH: if (w_req && (r_issued == w_num_m1)) w_next = S_DRAIN;
      // The final handshake implies every read has landed and been consumed
      S_DRAIN: if (w_pop && w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_flush) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_num       <= '0;
      r_issued    <= '0;
      r_delivered <= '0;
      r_inflight  <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else begin
      r_state <= w_next;
      if (w_flush) begin
        r_issued    <= '0;
        r_delivered <= '0;
        r_inflight  <= 1'b0;
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_count     <= '0;
      end else begin
        if (w_go) begin
          r_base      <= base_addr;
          r_num       <= num_inst;
          r_issued    <= '0;
          r_delivered <= '0;
        end
        if (w_req) r_issued <= r_issued + COUNT_W'(1);
        r_inflight <= w_req;
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop) begin
          r_rd_ptr    <= r_rd_ptr + PTR_W'(1);
          r_delivered <= r_delivered + COUNT_W'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + (PTR_W+1)'(1);
          2'b01:   r_count <= r_count - (PTR_W+1)'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Storage needs no reset: the head word is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= imem_read_data;
  end

  assign busy           = w_active;
  assign done           = (r_state == S_DONE);
  assign imem_read_req  = w_req;
  assign imem_read_addr = w_addr_sum[ADDR_WIDTH-1:0];
  assign inst_valid     = w_valid;
  assign inst_data      = w_valid ? r_mem[r_rd_ptr] : '0;
  assign inst_last      = w_last;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
//============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Self-checking bench for instruction_fetch_unit. Expected read
//               addresses and delivered words are queued when a fetch is
//               launched and compared as the DUT produces them.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_instruction_fetch_unit;

  localparam int DW = 32;
  localparam int AW = 11;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] num_inst;
  logic          flush;
  logic          busy;
  logic          done;
  logic          imem_read_req;
  logic [AW-1:0] imem_read_addr;
  logic [DW-1:0] imem_read_data = '0;
  logic          inst_valid;
  logic [DW-1:0] inst_data;
  logic          inst_last;
  logic          inst_ready;

  instruction_fetch_unit #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(4), .COUNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .num_inst(num_inst), .flush(flush), .busy(busy), .done(done),
    .imem_read_req(imem_read_req), .imem_read_addr(imem_read_addr),
    .imem_read_data(imem_read_data), .inst_valid(inst_valid),
    .inst_data(inst_data), .inst_last(inst_last), .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  // Instruction memory model: mem[i] = i, one-cycle read latency
  always @(posedge clk) begin
    if (imem_read_req) imem_read_data <= DW'(imem_read_addr);
  end

  logic [AW-1:0] addr_q [$];
  logic [DW:0]   word_q [$];   // {last, data}
  int n_total  = 0;
  int n_bad    = 0;
  int req_cnt  = 0;
  int hs_cnt   = 0;
  int done_cnt = 0;

  task automatic check(input string tag, input logic [DW:0] got, input logic [DW:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: sampled mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (imem_read_req) begin
          req_cnt++;
          check("addr_expected", addr_q.size() != 0, 1'b1);
          if (addr_q.size() != 0) check("read_addr", imem_read_addr, addr_q.pop_front());
        end
        if (inst_valid && inst_ready) begin
          hs_cnt++;
          check("word_expected", word_q.size() != 0, 1'b1);
          if (word_q.size() != 0) check("inst_word", {inst_last, inst_data}, word_q.pop_front());
        end
        if (done) done_cnt++;
      end
    end
  end

  // Queue expectations and pulse start for one cycle; returns 1ns into cycle T+1.
  task automatic launch(input logic [AW-1:0] base, input int num);
    logic [AW-1:0] a;
    for (int i = 0; i < num; i++) begin
      a = base + AW'(i);
      addr_q.push_back(a);
      word_q.push_back({(i == num - 1), DW'(a)});
    end
    start     = 1'b1;
    base_addr = base;
    num_inst  = CW'(num);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    logic seen = 1'b0;
    for (int k = 0; k < bound && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check(tag, seen, 1'b1);
  endtask

  task automatic check_drained(input string tag);
    check(tag, addr_q.size() + word_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_done"},  done, 0);
    check({tag, "_req"},   imem_read_req, 0);
    check({tag, "_addr"},  imem_read_addr, 0);
    check({tag, "_valid"}, inst_valid, 0);
    check({tag, "_last"},  inst_last, 0);
    check({tag, "_data"},  inst_data, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, h0, d0;
    logic seen;
    reset = 1'b1; start = 1'b0; flush = 1'b0; inst_ready = 1'b0;
    base_addr = '0; num_inst = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    // Basic: cycle-exact latency and ordering
    inst_ready = 1'b1;
    launch(11'h010, 4);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check($sformatf("basic_req_%0d", k),   imem_read_req, (k <= 4));
      check($sformatf("basic_valid_%0d", k), inst_valid, (k >= 3 && k <= 6));
      check($sformatf("basic_last_%0d", k),  inst_last, (k == 6));
      check($sformatf("basic_done_%0d", k),  done, (k == 7));
    end
    check_drained("basic_drained");

    // Backpressure: only FIFO_DEPTH reads issued, head held stable
    @(posedge clk); #1 inst_ready = 1'b0;
    r0 = req_cnt;
    launch(11'h020, 8);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (inst_valid) check("bp_hold", inst_data, 32'h20);
    end
    check("bp_reqs", req_cnt - r0, 4);
    check("bp_req_low", imem_read_req, 0);
    check("bp_valid", inst_valid, 1);
    @(posedge clk); #1 inst_ready = 1'b1;
    wait_done("bp_done", 40);
    check_drained("bp_drained");

    // Address wrap at the top of imem
    @(posedge clk); #1;
    launch(11'h7FE, 4);
    wait_done("wrap_done", 20);
    check_drained("wrap_drained");

    // Zero count: one busy cycle carrying the done pulse, no reads
    @(posedge clk); #1;
    r0 = req_cnt;
    launch(11'h055, 0);
    @(negedge clk);
    check("zero_busy1", busy, 1);
    check("zero_done1", done, 1);
    @(negedge clk);
    check("zero_busy2", busy, 0);
    check("zero_done2", done, 0);
    check("zero_reqs", req_cnt - r0, 0);

    // Flush after 5 handshakes with a read in flight
    @(posedge clk); #1;
    h0 = hs_cnt; d0 = done_cnt;
    launch(11'h000, 16);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (hs_cnt - h0 >= 5) seen = 1'b1;
    end
    check("flush_5hs", seen, 1'b1);
    check("flush_inflight", imem_read_req, 1);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    addr_q.delete(); word_q.delete();
    @(negedge clk);
    check("flush_valid1", inst_valid, 0);
    check("flush_busy", busy, 0);
    @(negedge clk);
    check("flush_valid2", inst_valid, 0);
    check("flush_no_done", done_cnt - d0, 0);
    @(posedge clk); #1;
    h0 = hs_cnt;
    launch(11'h100, 2);
    wait_done("post_flush_done", 20);
    check_drained("post_flush_drained");
    check("post_flush_words", hs_cnt - h0, 2);

    // Reset in the middle of a fetch
    @(posedge clk); #1 inst_ready = 1'b0;
    launch(11'h040, 8);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    addr_q.delete(); word_q.delete();
    @(negedge clk);
    check_all_zero("midreset");

    // start pulsed during DRAIN is ignored
    @(posedge clk); #1;
    r0 = req_cnt;
    launch(11'h200, 4);
    repeat (6) @(posedge clk);
    #1;
    start = 1'b1; base_addr = 11'h300; num_inst = 16'd1;
    @(posedge clk); #1 start = 1'b0; inst_ready = 1'b1;
    wait_done("drain_done", 20);
    check_drained("drain_drained");
    check("drain_reqs", req_cnt - r0, 4);
    repeat (3) @(negedge clk);
    check("drain_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
